// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: falling-edge pipeline latch with valid/ready flow control,
// a 2-entry skid buffer, synchronous flush and sticky HALT detection.
// Optional stall-cycle statistics are enabled by defining PIPE_STAGE_STATS_EN;
// without it o_stall_cnt reads as zero and no counter is built.
module pipe_stage_skid #(
    parameter int                  DATA_W      = 101,
    parameter int                  CTRL_W      = 3,
    parameter logic [CTRL_W-1:0]   CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_halt,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_halt,
    output logic              o_halted,
    output logic [1:0]        o_occupancy,
    output logic [15:0]       o_stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W-1:0]   head_data;
    logic [CTRL_W-1:0]   head_ctrl;
    logic                head_halt;
    logic [DATA_W-1:0]   skid_data;
    logic [CTRL_W-1:0]   skid_ctrl;
    logic                skid_halt;
    logic                halted;

    logic                push;
    logic                pop;
    logic                load_head_in;
    logic                load_head_skid;
    logic                load_skid;
    logic                halt_pop;

    // Handshake outputs come from registered state only, so downstream ready never ripples upstream.
    assign o_valid  = (state != EMPTY);
    assign o_ready  = (state != FULL) & ~halted & ~rst;
    assign push     = i_valid & o_ready;
    assign pop      = o_valid & i_ready;

    assign o_data   = head_data;
    assign o_ctrl   = o_valid ? head_ctrl : CTRL_BUBBLE;
    assign o_halt   = o_valid & head_halt;
    assign o_halted = halted;

    // Next-state and register-load decisions; flush beats a HALT pop, which beats normal flow.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        halt_pop       = 1'b0;
        if (i_flush) begin
            state_nxt = EMPTY;
        end else if (pop && head_halt) begin
            state_nxt = EMPTY;
            halt_pop  = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt    = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (push && pop) begin
                        state_nxt    = ONE;
                        load_head_in = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt      = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Occupancy reported as an entry count rather than the raw state encoding.
    always_comb begin
        o_occupancy = 2'd0;
        case (state)
            ONE:     o_occupancy = 2'd1;
            FULL:    o_occupancy = 2'd2;
            default: o_occupancy = 2'd0;
        endcase
    end

    // State register, updated on the falling edge like the other pipeline latches.
    always_ff @(negedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Head and skid storage; contents are kept across flush but hidden by o_valid.
    always_ff @(negedge clk) begin
        if (rst) begin
            head_data <= '0;
            head_ctrl <= '0;
            head_halt <= 1'b0;
            skid_data <= '0;
            skid_ctrl <= '0;
            skid_halt <= 1'b0;
        end else begin
            if (load_head_in) begin
                head_data <= i_data;
                head_ctrl <= i_ctrl;
                head_halt <= i_halt;
            end else if (load_head_skid) begin
                head_data <= skid_data;
                head_ctrl <= skid_ctrl;
                head_halt <= skid_halt;
            end
            if (load_skid) begin
                skid_data <= i_data;
                skid_ctrl <= i_ctrl;
                skid_halt <= i_halt;
            end
        end
    end

    // Sticky halted flag: set when a HALT beat leaves, cleared only by reset.
    always_ff @(negedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (halt_pop) begin
            halted <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_cnt;

    // Saturating count of edges where a valid beat was held back by downstream.
    always_ff @(negedge clk) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if (o_valid && !i_ready && !i_flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end

    assign o_stall_cnt = stall_cnt;
`else
    assign o_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and randomized checks of pipe_stage_skid against
// a queue-based reference model of the stage's transfer rules.
module tb_pipe_stage_skid;

    localparam int DATA_W = 101;
    localparam int CTRL_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic              halt;
    } beat_t;

    logic              clk;
    logic              rst;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic [CTRL_W-1:0] i_ctrl;
    logic              i_halt;
    logic              i_flush;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [CTRL_W-1:0] o_ctrl;
    logic              o_halt;
    logic              o_halted;
    logic [1:0]        o_occupancy;
    logic [15:0]       o_stall_cnt;

    int test_cnt = 0;
    int fail_cnt = 0;

    beat_t             q[$];
    logic              m_halted;
    int                m_stall;
    logic [DATA_W-1:0] m_head;

    pipe_stage_skid #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (3'b000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_ctrl      (i_ctrl),
        .i_halt      (i_halt),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_ctrl      (o_ctrl),
        .o_halt      (o_halt),
        .o_halted    (o_halted),
        .o_occupancy (o_occupancy),
        .o_stall_cnt (o_stall_cnt)
    );

    // Free-running clock; the DUT acts on the falling edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int expStall();
`ifdef PIPE_STAGE_STATS_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    // Compare every output against the model state built from the transfers so far.
    task automatic checkOutput();
        logic ev;
        ev = (q.size() > 0);
        checkValue("o_valid", {127'd0, o_valid}, {127'd0, ev});
        checkValue("o_ready", {127'd0, o_ready}, {127'd0, (q.size() < 2) && !m_halted && !rst});
        checkValue("o_data", {27'd0, o_data}, {27'd0, m_head});
        checkValue("o_ctrl", {125'd0, o_ctrl}, {125'd0, ev ? q[0].ctrl : 3'b000});
        checkValue("o_halt", {127'd0, o_halt}, {127'd0, ev && q[0].halt});
        checkValue("o_halted", {127'd0, o_halted}, {127'd0, m_halted});
        checkValue("o_occupancy", {126'd0, o_occupancy}, 128'(q.size()));
        checkValue("o_stall_cnt", {112'd0, o_stall_cnt}, 128'(expStall()));
    endtask

    // Model of one falling edge: a queue of at most two beats, flushed, halted or reset as a whole.
    task automatic modelEdge();
        int    n;
        logic  push;
        logic  pop;
        beat_t b;
        n    = q.size();
        push = i_valid && (n < 2) && !m_halted && !rst;
        pop  = (n > 0) && i_ready;
        b    = '{data: i_data, ctrl: i_ctrl, halt: i_halt};
        if (rst) m_stall = 0;
        else if (n > 0 && !i_ready && !i_flush && m_stall < 65535) m_stall++;
        if (rst) begin
            q.delete();
            m_halted = 1'b0;
            m_head   = '0;
        end else if (i_flush) begin
            q.delete();
        end else if (pop && q[0].halt) begin
            q.delete();
            m_halted = 1'b1;
        end else begin
            if (pop) q.delete(0);
            if (push) q.push_back(b);
        end
        if (q.size() > 0) m_head = q[0].data;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model with the DUT.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                                 input logic h, input logic fl, input logic rd, input logic rs);
        i_valid = v;
        i_data  = d;
        i_ctrl  = c;
        i_halt  = h;
        i_flush = fl;
        i_ready = rd;
        rst     = rs;
        @(posedge clk);
        checkOutput();
        @(negedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] rnd;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_ctrl  = '0;
        i_halt  = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        q.delete();
        m_halted = 1'b0;
        m_stall  = 0;
        m_head   = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkValue("reset o_valid", {127'd0, o_valid}, 128'd0);
        checkValue("reset o_ready", {127'd0, o_ready}, 128'd0);
        checkValue("reset o_data", {27'd0, o_data}, 128'd0);
        checkValue("reset o_occupancy", {126'd0, o_occupancy}, 128'd0);

        // Streaming: one beat per cycle with downstream always ready.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, DATA_W'(i), 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
            checkValue("stream o_data", {27'd0, o_data}, 128'(i));
            checkValue("stream o_occupancy", {126'd0, o_occupancy}, 128'd1);
        end
        applyStimulus(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure: two beats held, then drained in order.
        applyStimulus(1'b1, DATA_W'(8'h11), 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DATA_W'(8'h22), 3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DATA_W'(8'h33), 3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
        checkValue("bp o_occupancy", {126'd0, o_occupancy}, 128'd2);
        checkValue("bp o_ready", {127'd0, o_ready}, 128'd0);
        checkValue("bp o_data", {27'd0, o_data}, 128'h11);
        applyStimulus(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkValue("bp drain B", {27'd0, o_data}, 128'h22);
        applyStimulus(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkValue("bp drained", {127'd0, o_valid}, 128'd0);

        // Flush while full, with a third beat offered in the same cycle.
        applyStimulus(1'b1, DATA_W'(8'hA1), 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DATA_W'(8'hA2), 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DATA_W'(8'hCC), 3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
        checkValue("flush o_valid", {127'd0, o_valid}, 128'd0);
        checkValue("flush o_ctrl", {125'd0, o_ctrl}, 128'd0);
        checkValue("flush o_occupancy", {126'd0, o_occupancy}, 128'd0);
        applyStimulus(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkValue("flush C dropped", {127'd0, o_valid}, 128'd0);

        // HALT beat followed by a younger beat that must never appear.
        applyStimulus(1'b1, DATA_W'(8'h4B), 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DATA_W'(8'hDD), 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        checkValue("halt o_halt", {127'd0, o_halt}, 128'd1);
        applyStimulus(1'b1, DATA_W'(8'hEE), 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        checkValue("halt o_halted", {127'd0, o_halted}, 128'd1);
        checkValue("halt o_occupancy", {126'd0, o_occupancy}, 128'd0);
        checkValue("halt o_ready", {127'd0, o_ready}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, DATA_W'(8'hEE), 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkValue("halt sticky", {127'd0, o_halted}, 128'd1);
        applyStimulus(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
        checkValue("halt cleared", {127'd0, o_halted}, 128'd0);

        // Reset while full drops both entries; ready returns right after reset.
        applyStimulus(1'b1, DATA_W'(8'h55), 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, DATA_W'(8'h66), 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        checkValue("mid rst o_valid", {127'd0, o_valid}, 128'd0);
        checkValue("mid rst o_data", {27'd0, o_data}, 128'd0);
        checkValue("mid rst o_ctrl", {125'd0, o_ctrl}, 128'd0);
        checkValue("mid rst o_stall_cnt", {112'd0, o_stall_cnt}, 128'd0);
        rst = 1'b0;
        #1;
        checkValue("post rst o_ready", {127'd0, o_ready}, 128'd1);

        // Stall counting: one beat held for five edges with downstream not ready.
        applyStimulus(1'b1, DATA_W'(8'h77), 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
`ifdef PIPE_STAGE_STATS_EN
        checkValue("stall count", {112'd0, o_stall_cnt}, 128'd5);
`else
        checkValue("stall count", {112'd0, o_stall_cnt}, 128'd0);
`endif

        // Randomized traffic with occasional flush, halt and reset.
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(($urandom % 4) != 0, rnd, 3'($urandom), ($urandom % 20) == 0,
                          ($urandom % 16) == 0, ($urandom % 3) != 0, ($urandom % 25) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
